// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit that acts as the initiator on the single-cycle dmem port.
//
// It accepts one load or store at a time over req_valid/req_ready. It drives a word-aligned
// address, byte write enables and lane-shifted store data. The RAM acts on the falling edge,
// and this block drives and samples on the rising edge. Load data is sign- or zero-extended
// and returned with a one-cycle resp_valid pulse.
//
// Ports:
//   clock_mem, rst_n          rising-edge clock, async active-low reset
//   req_*                     request (store/load, size, unsigned, byte addr, right-aligned wdata)
//   resp_valid/rdata/err      completion pulse, extended load data (0 for stores/errors), error
//   addr_to_dmem              word-aligned offset from DMEM_BASE
//   store_data_to_dmem        lane-shifted store data
//   store_we_to_dmem          byte write enables (0 outside access cycles)
//   load_data_from_dmem       read-first word from the RAM
//
// Optional feature: define DMEM_LSU_MISALIGNED_SPLIT_EN to run word-crossing misaligned
// accesses as two back-to-back word accesses. Without it, any access whose offset is not a
// multiple of its size is rejected with resp_err.
module dmem_lsu #(
    parameter int          NUM_WORDS = 512,
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000
) (
    input  logic        clock_mem,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr_to_dmem,
    output logic [31:0] store_data_to_dmem,
    output logic [3:0]  store_we_to_dmem,
    input  logic [31:0] load_data_from_dmem
);
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC0} state_t;
`endif

    localparam logic [32:0] LIMIT = 33'(NUM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic        err_pend_q, err_pend_d;   // error seen; response goes out one cycle later
    logic        store_q, store_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] st_data_q, st_data_d;
    logic [3:0]  we_q, we_d;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
    logic        split_q, split_d;
    logic [31:0] st_hi_q, st_hi_d;
    logic [3:0]  we_hi_q, we_hi_d;
    logic [31:0] lo_q, lo_d;           // first word of a split load
    logic [7:0]  we8;
    logic [63:0] rd64;
    logic        cross;
`else
    logic        misalign;
`endif

    logic [31:0] offset;
    logic [1:0]  o;
    logic [2:0]  nbytes;
    logic [3:0]  mask;
    logic        in_range;
    logic        req_err;

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] sz,
                                        input logic u);
        case (sz)
            2'b00:   ext = u ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   ext = u ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    endfunction

    // Request classification
    always_comb begin
        offset = req_addr - DMEM_BASE;
        o      = req_addr[1:0];
        case (req_size)
            2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
            2'b10:   begin nbytes = 3'd4; mask = 4'b1111; end
            default: begin nbytes = 3'd0; mask = 4'b0000; end
        endcase
        // 33-bit sum so an offset near 2^32 cannot wrap into range
        in_range = ({1'b0, offset} + {30'b0, nbytes}) <= LIMIT;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
        cross   = ({1'b0, o} + nbytes) > 3'd4;
        we8     = {4'b0, mask} << o;
        req_err = (req_size == 2'b11) || !in_range;
`else
        misalign = (req_size == 2'b01 && o[0]) || (req_size == 2'b10 && o != 2'b00);
        req_err  = (req_size == 2'b11) || !in_range || misalign;
`endif
    end

    assign req_ready = (state_q == IDLE) && !err_pend_q;

    always_comb begin
        state_d      = state_q;
        err_pend_d   = 1'b0;
        store_d      = store_q;
        uns_d        = uns_q;
        size_d       = size_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'b0;
        addr_d       = addr_q;
        st_data_d    = st_data_q;
        we_d         = 4'b0;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
        split_d = split_q;
        st_hi_d = st_hi_q;
        we_hi_d = we_hi_q;
        lo_d    = lo_q;
        rd64    = {load_data_from_dmem, lo_q} >> {off_q, 3'b000};
`endif
        case (state_q)
            IDLE: begin
                if (err_pend_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else if (req_valid) begin
                    store_d = req_store;
                    uns_d   = req_unsigned;
                    size_d  = req_size;
                    off_d   = o;
                    if (req_err) begin
                        err_pend_d = 1'b1;
                    end else begin
                        state_d   = ACC0;
                        addr_d    = {offset[31:2], 2'b00};
                        st_data_d = req_wdata << {o, 3'b000};
                        we_d      = req_store ? (mask << o) : 4'b0;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
                        split_d = cross;
                        // o is never 0 when split, so the 32-bit shift case is unused
                        st_hi_d = req_wdata >> (6'd32 - {1'b0, o, 3'b000});
                        we_hi_d = req_store ? we8[7:4] : 4'b0;
`endif
                    end
                end
            end
            ACC0: begin
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
                if (split_q) begin
                    state_d   = ACC1;
                    lo_d      = load_data_from_dmem;
                    addr_d    = addr_q + 32'd4;
                    st_data_d = st_hi_q;
                    we_d      = we_hi_q;
                end else
`endif
                begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = store_q ? 32'b0
                                 : ext(load_data_from_dmem >> {off_q, 3'b000}, size_q, uns_q);
                end
            end
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
            ACC1: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = store_q ? 32'b0 : ext(rd64[31:0], size_q, uns_q);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_mem or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            err_pend_q   <= 1'b0;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b0;
            off_q        <= 2'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            addr_q       <= 32'b0;
            st_data_q    <= 32'b0;
            we_q         <= 4'b0;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
            split_q <= 1'b0;
            st_hi_q <= 32'b0;
            we_hi_q <= 4'b0;
            lo_q    <= 32'b0;
`endif
        end else begin
            state_q      <= state_d;
            err_pend_q   <= err_pend_d;
            store_q      <= store_d;
            uns_q        <= uns_d;
            size_q       <= size_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            addr_q       <= addr_d;
            st_data_q    <= st_data_d;
            we_q         <= we_d;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
            split_q <= split_d;
            st_hi_q <= st_hi_d;
            we_hi_q <= we_hi_d;
            lo_q    <= lo_d;
`endif
        end
    end

    assign resp_valid         = resp_valid_q;
    assign resp_err           = resp_err_q;
    assign resp_rdata         = resp_rdata_q;
    assign addr_to_dmem       = addr_q;
    assign store_data_to_dmem = st_data_q;
    assign store_we_to_dmem   = we_q;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that acts as the initiator on the single-cycle data-memory port. It accepts one load or store request at a time from the core over a valid/ready handshake and generates the word-aligned address, byte-lane write enables and lane-shifted store data. It sign- or zero-extends load data and returns it with a one-cycle response pulse. It sits between the execute stage and the dmem port of `MemorySingleCycle`: the RAM writes and reads on the falling edge, and this block drives and samples on the rising edge.

## Interface
- `NUM_WORDS`, 512, dmem depth in 32-bit words; sets the legal address range.
- `DMEM_BASE`, 32'h0000_0000, byte address of dmem word 0.
- `clock_mem` in 1: single clock, rising-edge logic.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse (loads and stores).
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`; set for an illegal size, an out-of-range access or an unsupported misaligned access.
- `addr_to_dmem` out 32: word-aligned offset (`req_addr - DMEM_BASE`, bits [1:0] = 0).
- `store_data_to_dmem` out 32: lane-shifted store data.
- `store_we_to_dmem` out 4: byte write enables.
- `load_data_from_dmem` in 32: read-first word from the RAM.

## Operation
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch the request and classify it:
    - error: go to IDLE and pulse `resp_valid` with `resp_err`=1.
    - aligned, or misaligned but contained in one word: go to ACC0.
    - misaligned and crossing a word boundary: go to ACC0 and mark the request as split.
  - ACC0: the first word is on the port.
  - ACC1: the second word (address +4, wrapping modulo 2^32) is on the port.
  - Return to IDLE from ACC0 (unsplit) or ACC1 (split) and pulse `resp_valid`.
- Offset is o = `req_addr[1:0]`; mask m is 0001, 0011 or 1111 for byte, half or word.
- First access: `we` = (m<<o)[3:0], data = `req_wdata` << 8o.
- Second access: `we` = (m<<o)[7:4], data = `req_wdata` >> 8(4-o).
- Loads use `we`=0. `load_data_from_dmem` is captured at the rising edge ending each access cycle.
- Result: the 64-bit value {hi, lo} >> 8o, truncated to the access size, then sign- or zero-extended.
- `store_we_to_dmem` is 0 in every cycle outside ACC0/ACC1, so the RAM never sees a stray write.
- Range check: offset plus size must be ≤ 4·`NUM_WORDS`. Otherwise error with no dmem access, including when the second word of a split falls out of range.
- Back-to-back: the response cycle is IDLE, so a new request can be accepted in the same cycle `resp_valid` is high.

## Timing
- Reset (async, `rst_n`=0):
  - state IDLE, `req_ready`=1;
  - `resp_valid`, `resp_err` = 0;
  - `resp_rdata`, `addr_to_dmem`, `store_data_to_dmem` = 0;
  - `store_we_to_dmem`=0 immediately, without waiting for a clock edge.
- Reset during ACC0 or ACC1 abandons the access. A split store may leave only its first word written, and no response is issued.
- Request accepted at rising edge k:
  - port outputs are valid from edge k;
  - the RAM acts at the falling edge in cycle k;
  - unsplit: `resp_valid` is high in the cycle after edge k+1 (latency 2);
  - split: second access at edge k+1, `resp_valid` after edge k+2 (latency 3).
- Error requests pulse `resp_valid` after edge k+1 (latency 2).
- `resp_valid` is high for exactly one cycle and is never high while in ACC0/ACC1.

## Configuration
- `DMEM_LSU_MISALIGNED_SPLIT_EN` defined: misaligned accesses that cross a word boundary run as two-access splits, as described above.
- Not defined: any access with o not a multiple of its size returns `resp_err`=1 with no dmem access (latency 2), and ACC1 is absent from the RTL.

## Test plan
- Reset: hold `rst_n`=0 while the block is in ACC0 for a store -> `store_we_to_dmem`=0 at once, `req_ready`=1, no `resp_valid`.
- Store byte 0xA5 to 0x0000_0006, then load byte from 0x0000_0006:
  - the store drives `addr_to_dmem`=0x4, `we`=0100, data=0x00A5_0000;
  - the signed load returns 0xFFFF_FFA5;
  - the unsigned load returns 0x0000_00A5.
- Store word 0x1122_3344 to 0x10 -> load half from 0x12 returns 0x0000_1122 with latency 2. Issue a back-to-back request in the response cycle and check it is accepted.
- Split (macro on): store word 0xDEAD_BEEF to 0x0000_0023:
  - first access: addr 0x20, `we`=1000, data=0xEF00_0000;
  - second access: addr 0x24, `we`=0111, data=0x00DE_ADBE;
  - a word load from 0x23 returns 0xDEAD_BEEF with latency 3.
- Macro off: load half from 0x0000_0003 -> `resp_err`=1, `resp_rdata`=0, no access cycle.
- Range, with `NUM_WORDS`=512:
  - store word to 0x7FC succeeds;
  - store to 0x800 gives `resp_err`=1 and `we` stays 0;
  - `req_size`=11 gives `resp_err`=1.
